// File: rtl/column_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : compute / column_sweep_ctrl
//  Purpose  : One Jacobi relaxation sweep of a grid column in 5.27 fixed
//             point. Streams center/left/right rows, forms the up/center/down
//             window, injects Dirichlet boundaries and writes the updated
//             nodes into the opposite ping-pong bank.
//  Revision : 1.0 - initial release
// ============================================================================

// Single node update: c + alpha*(up+down+left+right-4c), wrapping 5.27.
// Nodes pinned at +8.0 / -8.0 are source terminals and pass through.
module compute (
    input  logic [31:0] alpha,
    input  logic [31:0] center,
    input  logic [31:0] up,
    input  logic [31:0] down,
    input  logic [31:0] left,
    input  logic [31:0] right,
    output logic [31:0] result
);
    logic [31:0] w_sum;
    logic [63:0] w_prod;
    logic        w_pinned;
    logic        w_unused_prod;

    assign w_sum    = up + down + left + right - {center[29:0], 2'b00};
    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_prod   = {{32{alpha[31]}}, alpha} * {{32{w_sum[31]}}, w_sum};
    assign w_pinned = (center == 32'h4000_0000) || (center == 32'hC000_0000);
    assign result   = w_pinned ? center : (center + w_prod[58:27]);

    // Bits discarded by the 5.27 rescale.
    assign w_unused_prod = ^{w_prod[63:59], w_prod[26:0]};
endmodule

module column_sweep_ctrl #(
    parameter int ROWS = 32,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   alpha,
    input  logic [31:0]   bnd_value,
    input  logic          edge_left,
    input  logic          edge_right,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   q_center,
    input  logic [31:0]   q_left,
    input  logic [31:0]   q_right,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          buf_sel,
    output logic          busy,
    output logic          done,
    output logic [15:0]   sweep_count
);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_RUN   = 2'd1;
    localparam logic [1:0]    S_DRAIN = 2'd2;
    localparam logic [1:0]    S_DONE  = 2'd3;
    localparam logic [AW-1:0] c_last  = AW'(ROWS - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_drain;
    logic [AW-1:0] r_rd_addr;
    logic [31:0]   r_alpha;
    logic [31:0]   r_bnd;
    logic          r_edge_l;
    logic          r_edge_r;
    logic          r_buf_sel;
    logic [15:0]   r_count;

    // Read-data stage (row whose words are on q_* this cycle).
    logic          r_q_vld;
    logic [AW-1:0] r_q_row;
    // Compute stage: window center row and its aligned neighbors.
    logic          r_c_vld;
    logic [AW-1:0] r_c_row;
    logic [31:0]   r_win_u;
    logic [31:0]   r_win_c;
    logic [31:0]   r_left_d;
    logic [31:0]   r_right_d;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;

    logic [31:0]   w_down;
    logic [31:0]   w_result;

    // Sequencer: accepts start, walks read addresses, drains, closes the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_drain   <= 2'd0;
            r_rd_addr <= '0;
            r_alpha   <= 32'd0;
            r_bnd     <= 32'd0;
            r_edge_l  <= 1'b0;
            r_edge_r  <= 1'b0;
            r_buf_sel <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_rd_addr <= '0;
                        r_drain   <= 2'd0;
                        r_alpha   <= alpha;
                        r_bnd     <= bnd_value;
                        r_edge_l  <= edge_left;
                        r_edge_r  <= edge_right;
                    end
                end
                S_RUN: begin
                    if (r_rd_addr == c_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= 2'd0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Three cycles cover memory latency, window and write stage.
                    if (r_drain == 2'd2) begin
                        r_state   <= S_DONE;
                        r_buf_sel <= ~r_buf_sel;
                        r_count   <= r_count + 16'd1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window shift on each returned center word; neighbors delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_vld   <= 1'b0;
            r_q_row   <= '0;
            r_c_vld   <= 1'b0;
            r_c_row   <= '0;
            r_win_u   <= 32'd0;
            r_win_c   <= 32'd0;
            r_left_d  <= 32'd0;
            r_right_d <= 32'd0;
        end else begin
            r_q_vld <= (r_state == S_RUN);
            r_q_row <= r_rd_addr;
            r_c_vld <= r_q_vld;
            r_c_row <= r_q_row;
            if (r_q_vld) begin
                r_win_c   <= q_center;
                r_win_u   <= (r_q_row == '0) ? r_bnd : r_win_c;
                r_left_d  <= r_edge_l ? r_bnd : q_left;
                r_right_d <= r_edge_r ? r_bnd : q_right;
            end
        end
    end

    // The down neighbor is the live center read (row+1); past the last row
    // no read exists, so the boundary value takes its place.
    assign w_down = (r_c_row == c_last) ? r_bnd : q_center;

    compute u_compute (
        .alpha  (r_alpha),
        .center (r_win_c),
        .up     (r_win_u),
        .down   (w_down),
        .left   (r_left_d),
        .right  (r_right_d),
        .result (w_result)
    );

    // Registered write port into the destination bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= r_c_vld;
            if (r_c_vld) begin
                r_wr_addr <= r_c_row;
                r_wr_data <= w_result;
            end
        end
    end

    assign rd_addr     = r_rd_addr;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign buf_sel     = r_buf_sel;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign sweep_count = r_count;
endmodule
`default_nettype wire
